// File: rtl/song_reader.sv
// song_reader: steps through one song in the song ROM, issuing note/duration pairs to the note player.
// Define SONG_READER_LOOP_EN to make songs repeat instead of holding at the end.
`default_nettype none

module song_reader #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int ADDR_W = 5,
    parameter int SONG_W = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       play,
    input  logic [SONG_W-1:0]          song,
    input  logic                       note_done,
    output logic [SONG_W+ADDR_W-1:0]   rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]    rom_data,
    output logic                       new_note,
    output logic [NOTE_W-1:0]          note,
    output logic [DUR_W-1:0]           duration,
    output logic                       song_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DATA  = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_END   = 3'd5,
        S_HOLD  = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [SONG_W-1:0]   song_q;
    logic [NOTE_W-1:0]   note_q;
    logic [DUR_W-1:0]    dur_q;
    logic                new_note_q;
    logic                song_done_q;

    assign rom_addr  = {song_q, addr_q};
    assign new_note  = new_note_q;
    assign note      = note_q;
    assign duration  = dur_q;
    assign song_done = song_done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            song_q      <= '0;
            note_q      <= '0;
            dur_q       <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (play) begin
                        song_q  <= song;
                        state_q <= S_FETCH;
                    end
                end
                S_END: begin
                    addr_q <= '0;
`ifdef SONG_READER_LOOP_EN
                    state_q <= play ? S_FETCH : S_IDLE;
`else
                    state_q <= S_HOLD;
`endif
                end
                S_HOLD: begin
                    if (!play) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    // Pause beats song change beats normal sequencing; a note_done
                    // that lands with the pause still consumes the current entry.
                    if (!play) begin
                        state_q <= S_IDLE;
                        if (state_q == S_WAIT && note_done) begin
                            addr_q <= addr_q + ADDR_ONE;
                        end
                    end else if (song != song_q) begin
                        song_q  <= song;
                        addr_q  <= '0;
                        state_q <= S_FETCH;
                    end else begin
                        case (state_q)
                            S_FETCH: state_q <= S_DATA;
                            S_DATA: begin
                                if (rom_data == '0) begin
                                    song_done_q <= 1'b1;
                                    state_q     <= S_END;
                                end else begin
                                    note_q     <= rom_data[NOTE_W+DUR_W-1:DUR_W];
                                    dur_q      <= rom_data[DUR_W-1:0];
                                    new_note_q <= 1'b1;
                                    state_q    <= S_ISSUE;
                                end
                            end
                            S_ISSUE: state_q <= S_WAIT;
                            S_WAIT: begin
                                if (note_done) begin
                                    if (addr_q == ADDR_LAST) begin
                                        song_done_q <= 1'b1;
                                        state_q     <= S_END;
                                    end else begin
                                        addr_q  <= addr_q + ADDR_ONE;
                                        state_q <= S_FETCH;
                                    end
                                end
                            end
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_song_reader.sv
// tb_song_reader: directed table plus hand-written sequences against a behavioural song ROM.
`default_nettype none

module tb_song_reader;

    logic        clk;
    logic        reset;
    logic        play;
    logic [1:0]  song;
    logic        note_done;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic        new_note;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic        song_done;

    song_reader dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .song      (song),
        .note_done (note_done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .new_note  (new_note),
        .note      (note),
        .duration  (duration),
        .song_done (song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] rom_mem [128];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    typedef struct packed {
        logic       play;
        logic [1:0] song;
        logic       nd;
        logic [6:0] addr;
        logic       nn;
        logic [5:0] note;
        logic [5:0] dur;
        logic       sd;
    } vec_t;

    vec_t tbl [24];

    int n_checks = 0;
    int n_pass   = 0;
    int nn_cnt   = 0;
    int sd_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (new_note === 1'b1) nn_cnt++;
        if (song_done === 1'b1) sd_cnt++;
    endtask

    task automatic wait_nn(input string name, input int en, input int ed, output int cyc);
        cyc = 0;
        while (new_note !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        chk({name, " new_note"}, 32'(new_note), 32'd1);
        chk({name, " note"}, 32'(note), 32'(en));
        chk({name, " duration"}, 32'(duration), 32'(ed));
    endtask

    task automatic pulse_after();
        step();
        step();
        step();
        note_done = 1'b1;
        step();
        note_done = 1'b0;
    endtask

    initial begin
        int cyc;
        int base;
        reset = 1'b1;
        play = 1'b0;
        song = 2'd0;
        note_done = 1'b0;
        for (int i = 0; i < 128; i++) rom_mem[i] = 12'd0;
        for (int i = 0; i < 32; i++) rom_mem[i] = {6'(i + 1), 6'(2 * i + 1)};
        rom_mem[32] = {6'd5, 6'd10};
        rom_mem[33] = {6'd7, 6'd3};
        rom_mem[34] = {6'd9, 6'd1};
        rom_mem[64] = {6'd20, 6'd5};
        for (int i = 0; i < 4; i++) rom_mem[96 + i] = {6'(i + 1), 6'(i + 1)};

        // play, song, nd, addr, nn, note, dur, sd
        tbl[0]  = '{1'b1, 2'd1, 1'b0, 7'h20, 1'b0, 6'd0, 6'd0,  1'b0};
        tbl[1]  = '{1'b1, 2'd1, 1'b0, 7'h20, 1'b0, 6'd0, 6'd0,  1'b0};
        tbl[2]  = '{1'b1, 2'd1, 1'b0, 7'h20, 1'b1, 6'd5, 6'd10, 1'b0};
        tbl[3]  = '{1'b1, 2'd1, 1'b0, 7'h20, 1'b0, 6'd5, 6'd10, 1'b0};
        tbl[4]  = '{1'b1, 2'd1, 1'b0, 7'h20, 1'b0, 6'd5, 6'd10, 1'b0};
        tbl[5]  = '{1'b1, 2'd1, 1'b0, 7'h20, 1'b0, 6'd5, 6'd10, 1'b0};
        tbl[6]  = '{1'b1, 2'd1, 1'b1, 7'h21, 1'b0, 6'd5, 6'd10, 1'b0};
        tbl[7]  = '{1'b1, 2'd1, 1'b0, 7'h21, 1'b0, 6'd5, 6'd10, 1'b0};
        tbl[8]  = '{1'b1, 2'd1, 1'b0, 7'h21, 1'b1, 6'd7, 6'd3,  1'b0};
        tbl[9]  = '{1'b1, 2'd1, 1'b0, 7'h21, 1'b0, 6'd7, 6'd3,  1'b0};
        tbl[10] = '{1'b1, 2'd1, 1'b0, 7'h21, 1'b0, 6'd7, 6'd3,  1'b0};
        tbl[11] = '{1'b1, 2'd1, 1'b0, 7'h21, 1'b0, 6'd7, 6'd3,  1'b0};
        tbl[12] = '{1'b1, 2'd1, 1'b1, 7'h22, 1'b0, 6'd7, 6'd3,  1'b0};
        tbl[13] = '{1'b1, 2'd1, 1'b0, 7'h22, 1'b0, 6'd7, 6'd3,  1'b0};
        tbl[14] = '{1'b1, 2'd1, 1'b0, 7'h22, 1'b1, 6'd9, 6'd1,  1'b0};
        tbl[15] = '{1'b1, 2'd1, 1'b0, 7'h22, 1'b0, 6'd9, 6'd1,  1'b0};
        tbl[16] = '{1'b1, 2'd1, 1'b0, 7'h22, 1'b0, 6'd9, 6'd1,  1'b0};
        tbl[17] = '{1'b1, 2'd1, 1'b0, 7'h22, 1'b0, 6'd9, 6'd1,  1'b0};
        tbl[18] = '{1'b1, 2'd1, 1'b1, 7'h23, 1'b0, 6'd9, 6'd1,  1'b0};
        tbl[19] = '{1'b1, 2'd1, 1'b0, 7'h23, 1'b0, 6'd9, 6'd1,  1'b0};
        tbl[20] = '{1'b1, 2'd1, 1'b0, 7'h23, 1'b0, 6'd9, 6'd1,  1'b1};
        tbl[21] = '{1'b1, 2'd1, 1'b0, 7'h20, 1'b0, 6'd9, 6'd1,  1'b0};
`ifdef SONG_READER_LOOP_EN
        tbl[22] = '{1'b1, 2'd1, 1'b0, 7'h20, 1'b0, 6'd9, 6'd1,  1'b0};
        tbl[23] = '{1'b1, 2'd1, 1'b0, 7'h20, 1'b1, 6'd5, 6'd10, 1'b0};
`else
        tbl[22] = '{1'b1, 2'd1, 1'b0, 7'h20, 1'b0, 6'd9, 6'd1,  1'b0};
        tbl[23] = '{1'b1, 2'd1, 1'b0, 7'h20, 1'b0, 6'd9, 6'd1,  1'b0};
`endif

        #12;
        chk("reset outputs", {rom_addr, new_note, note, duration, song_done}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            play      = tbl[i].play;
            song      = tbl[i].song;
            note_done = tbl[i].nd;
            step();
            chk($sformatf("vec%0d", i), {rom_addr, new_note, note, duration, song_done},
                {tbl[i].addr, tbl[i].nn, tbl[i].note, tbl[i].dur, tbl[i].sd});
        end
        note_done = 1'b0;

        // Pause in WAIT_DONE at addr 2 of song 3, then resume.
        play = 1'b0;
        step();
        song = 2'd3;
        play = 1'b1;
        wait_nn("s3 e0", 1, 1, cyc);
        pulse_after();
        wait_nn("s3 e1", 2, 2, cyc);
        pulse_after();
        wait_nn("s3 e2", 3, 3, cyc);
        step();
        play = 1'b0;
        base = nn_cnt;
        for (int i = 0; i < 10; i++) step();
        chk("pause no new_note", 32'(nn_cnt - base), 32'd0);
        chk("pause rom_addr", 32'(rom_addr), 32'h62);
        chk("pause note held", 32'(note), 32'd3);
        play = 1'b1;
        wait_nn("resume", 3, 3, cyc);
        chk("resume latency", 32'(cyc), 32'd3);

        // note_done coinciding with pause consumes the entry.
        step();
        play = 1'b0;
        note_done = 1'b1;
        step();
        note_done = 1'b0;
        step();
        step();
        chk("pause+done rom_addr", 32'(rom_addr), 32'h63);
        play = 1'b1;
        wait_nn("pause+done", 4, 4, cyc);

        // Switch to song 0 and walk to entry 7, then switch to song 2.
        step();
        song = 2'd0;
        step();
        chk("switch s0 rom_addr", 32'(rom_addr), 32'h00);
        wait_nn("s0 e0", 1, 1, cyc);
        for (int i = 1; i < 8; i++) begin
            pulse_after();
            wait_nn($sformatf("s0 e%0d", i), i + 1, 2 * i + 1, cyc);
        end
        base = sd_cnt;
        step();
        song = 2'd2;
        note_done = 1'b1;
        step();
        note_done = 1'b0;
        chk("switch s2 rom_addr", 32'(rom_addr), 32'h40);
        wait_nn("s2 e0", 20, 5, cyc);
        chk("switch no song_done", 32'(sd_cnt - base), 32'd0);

        // Asynchronous reset in WAIT_DONE.
        step();
        #2;
        reset = 1'b1;
        play = 1'b0;
        song = 2'd0;
        #1;
        chk("async reset outputs", {rom_addr, new_note, note, duration, song_done}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Unterminated song: ends after the 32nd note_done.
        play = 1'b1;
        for (int i = 0; i < 32; i++) begin
            wait_nn($sformatf("full e%0d", i), i + 1, 2 * i + 1, cyc);
            pulse_after();
        end
        chk("full song_done", 32'(song_done), 32'd1);
        chk("full no new_note at end", 32'(new_note), 32'd0);
`ifdef SONG_READER_LOOP_EN
        wait_nn("loop restart", 1, 1, cyc);
`else
        step();
        chk("hold rom_addr", 32'(rom_addr), 32'h00);
        chk("hold song_done low", 32'(song_done), 32'd0);
        base = nn_cnt;
        for (int i = 0; i < 6; i++) step();
        chk("hold no replay", 32'(nn_cnt - base), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
